instr_encoder_writer: RTL and testbench

INSTR_ENCODER_WRITER -- requirements
Module: instr_encoder_writer

---
 rtl/instr_encoder_writer_pkg.sv | 28 ++
 rtl/instr_encode.sv | 28 ++
 rtl/instr_encoder_writer.sv | 123 ++++++++++++
 tb/tb_instr_encoder_writer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_writer_pkg.sv
// rtl/instr_encoder_writer_pkg.sv - shared format codes, FSM encoding and address limits for the program loader
package instr_encoder_writer_pkg;

    typedef enum logic [1:0] {
        FMT_R    = 2'b00,
        FMT_I    = 2'b01,
        FMT_S    = 2'b10,
        FMT_RSVD = 2'b11
    } fmt_e;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_WRITE  = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam int          ADDR_W    = 8;
    localparam int          DATA_W    = 32;
    localparam int          COUNT_W   = 7;
    localparam logic [7:0]  ADDR_STEP = 8'd4;
    localparam logic [6:0]  MAX_WORDS = 7'd64;
    localparam logic [7:0]  LAST_ADDR = 8'hFC;

    function automatic logic fmt_is_legal(input logic [1:0] f);
        return f != 2'(FMT_RSVD);
    endfunction

endpackage

// File: rtl/instr_encode.sv
// rtl/instr_encode.sv - combinational RV32 field packer for R/I/S formats
module instr_encode
    import instr_encoder_writer_pkg::*;
(
    input  logic [1:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [11:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_legal
);

    always_comb begin
        o_word  = '0;
        o_legal = fmt_is_legal(i_fmt);
        case (fmt_e'(i_fmt))
            FMT_R:   o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            FMT_I:   o_word = {i_imm, i_rs1, i_funct3, i_rd, i_opcode};
            FMT_S:   o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            default: o_word = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_writer.sv
// rtl/instr_encoder_writer.sv - accepts instruction fields, encodes them and writes words into instruction memory
module instr_encoder_writer
    import instr_encoder_writer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          fmt,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic [4:0]          rd,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic [11:0]         imm,
    input  logic                finish,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [COUNT_W-1:0]  count,
    output logic                done,
    output logic                err
);

    state_e              r_state;
    state_e              w_next_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_word;
    logic [COUNT_W-1:0]  r_count;
    logic                r_err;
    logic [DATA_W-1:0]   w_word;
    logic                w_legal;
    logic                w_accept;
    logic                w_reject;

    instr_encode u_encode (
        .i_fmt    (fmt),
        .i_opcode (opcode),
        .i_funct3 (funct3),
        .i_funct7 (funct7),
        .i_rd     (rd),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .i_imm    (imm),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_ACCEPT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // in_valid is checked before finish so a word arriving with finish is never dropped
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        mem_we       = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            ST_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (w_legal) begin
                        w_accept     = 1'b1;
                        w_next_state = ST_WRITE;
                    end else begin
                        w_reject = 1'b1;
                    end
                end else if (finish) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_WRITE: begin
                mem_we       = 1'b1;
                w_next_state = (r_addr == LAST_ADDR) ? ST_DONE : ST_ACCEPT;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                w_next_state = ST_ACCEPT;
            end
        endcase
    end

    // The address stops at LAST_ADDR so it never wraps back over word 0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_word  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_word <= w_word;
            end
            if (w_reject) begin
                r_err <= 1'b1;
            end
            if (mem_we) begin
                if (r_addr != LAST_ADDR) begin
                    r_addr <= r_addr + ADDR_STEP;
                end
                if (r_count != MAX_WORDS) begin
                    r_count <= r_count + 7'd1;
                end
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_word;
    assign count     = r_count;
    assign err       = r_err;

endmodule

// File: tb/tb_instr_encoder_writer.sv
// tb/tb_instr_encoder_writer.sv - vector table plus scoreboard bench for instr_encoder_writer
module tb_instr_encoder_writer;

    typedef struct {
        logic [1:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic        finish;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [6:0]  count;
    logic        done;
    logic        err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_writes = 0;
    int          n_pushed = 0;
    logic [7:0]  m_addr;
    logic [6:0]  m_count;
    exp_t        sbq[$];
    vec_t        tbl[6];

    instr_encoder_writer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .finish    (finish),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input vec_t v);
        case (v.fmt)
            2'b00:   return {v.funct7, v.rs2, v.rs1, v.funct3, v.rd, v.opcode};
            2'b01:   return {v.imm, v.rs1, v.funct3, v.rd, v.opcode};
            default: return {v.imm[11:5], v.rs2, v.rs1, v.funct3, v.imm[4:0], v.opcode};
        endcase
    endfunction

    task automatic drive(input vec_t v);
        fmt    = v.fmt;
        opcode = v.opcode;
        funct3 = v.funct3;
        funct7 = v.funct7;
        rd     = v.rd;
        rs1    = v.rs1;
        rs2    = v.rs2;
        imm    = v.imm;
    endtask

    // Returns 1ns after the accepting edge, i.e. with the DUT in its write cycle
    task automatic send(input vec_t v, input bit hold);
        int t = 0;
        drive(v);
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (in_ready !== 1'b1) begin
            chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            sbq.push_back('{m_addr, v.exp});
            n_pushed++;
            m_addr  = m_addr + 8'd4;
            m_count = m_count + 7'd1;
        end
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset   = 1'b0;
        m_addr  = 8'h00;
        m_count = 7'd0;
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_writes++;
            if (sbq.size() == 0) begin
                chk("unexpected_write", {31'd0, mem_we}, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_addr", {24'd0, mem_addr}, {24'd0, e.addr});
                chk("sb_data", mem_wdata, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2'b00, 7'h33, 3'd0, 7'h00, 5'd3,  5'd1,  5'd2,  12'hABC, 32'h002081B3};
        tbl[1] = '{2'b01, 7'h13, 3'd0, 7'h7F, 5'd5,  5'd0,  5'd31, 12'hFFF, 32'hFFF00293};
        tbl[2] = '{2'b10, 7'h23, 3'd2, 7'h55, 5'd9,  5'd1,  5'd2,  12'h008, 32'h0020A423};
        tbl[3] = '{2'b00, 7'h33, 3'd0, 7'h20, 5'd4,  5'd5,  5'd6,  12'h000, 32'h40628233};
        tbl[4] = '{2'b01, 7'h03, 3'd2, 7'h00, 5'd7,  5'd2,  5'd0,  12'hFFC, 32'hFFC12383};
        tbl[5] = '{2'b10, 7'h23, 3'd2, 7'h00, 5'd0,  5'd31, 5'd31, 12'hFFF, 32'hFFFFAFA3};

        in_valid = 1'b0;
        finish   = 1'b0;
        drive(tbl[0]);
        do_reset();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mem_we",   {31'd0, mem_we},   32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_wdata",    mem_wdata,         32'd0);
        chk("rst_count",    {25'd0, count},    32'd0);
        chk("rst_done",     {31'd0, done},     32'd0);
        chk("rst_err",      {31'd0, err},      32'd0);

        for (int i = 0; i < 6; i++) begin
            logic [7:0] a;
            a = m_addr;
            send(tbl[i], 1'b0);
            chk("tbl_we",    {31'd0, mem_we},   32'd1);
            chk("tbl_ready", {31'd0, in_ready}, 32'd0);
            chk("tbl_addr",  {24'd0, mem_addr}, {24'd0, a});
            @(posedge clk); #1;
            chk("tbl_count", {25'd0, count},    {25'd0, m_count});
        end

        send(tbl[3], 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        m_addr  = 8'h00;
        m_count = 7'd0;
        chk("rstw_mem_we", {31'd0, mem_we},   32'd0);
        chk("rstw_addr",   {24'd0, mem_addr}, 32'd0);
        chk("rstw_count",  {25'd0, count},    32'd0);
        send(tbl[1], 1'b0);
        @(posedge clk); #1;
        chk("rstw_next_count", {25'd0, count}, 32'd1);

        finish = 1'b1;
        send(tbl[2], 1'b0);
        @(posedge clk); #1;
        finish = 1'b0;
        chk("prio_done",  {31'd0, done},     32'd0);
        chk("prio_ready", {31'd0, in_ready}, 32'd1);
        chk("prio_count", {25'd0, count},    32'd2);

        drive(tbl[0]);
        fmt      = 2'b11;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rsvd_err",   {31'd0, err},      32'd1);
        chk("rsvd_ready", {31'd0, in_ready}, 32'd1);
        chk("rsvd_we",    {31'd0, mem_we},   32'd0);
        @(posedge clk); #1;
        chk("rsvd_count", {25'd0, count},    32'd2);
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        chk("fin_done",  {31'd0, done},     32'd1);
        chk("fin_ready", {31'd0, in_ready}, 32'd0);
        drive(tbl[0]);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("fin_hold_we",   {31'd0, mem_we}, 32'd0);
            chk("fin_hold_done", {31'd0, done},   32'd1);
        end
        in_valid = 1'b0;

        do_reset();
        chk("rst2_err",  {31'd0, err},  32'd0);
        chk("rst2_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 64; i++) begin
            vec_t v;
            v.fmt    = 2'($urandom_range(0, 2));
            v.opcode = 7'($urandom);
            v.funct3 = 3'($urandom);
            v.funct7 = 7'($urandom);
            v.rd     = 5'($urandom);
            v.rs1    = 5'($urandom);
            v.rs2    = 5'($urandom);
            v.imm    = 12'($urandom);
            v.exp    = model(v);
            send(v, 1'b1);
        end
        chk("last_addr", {24'd0, mem_addr}, 32'h0000_00FC);
        chk("last_we",   {31'd0, mem_we},   32'd1);
        @(posedge clk); #1;
        chk("full_done",  {31'd0, done},     32'd1);
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        chk("full_count", {25'd0, count},    32'd64);
        chk("full_addr",  {24'd0, mem_addr}, 32'h0000_00FC);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("full_hold_we", {31'd0, mem_we}, 32'd0);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("sb_empty",  sbq.size(), 32'd0);
        chk("sb_writes", n_writes,   n_pushed);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
